// File: rtl/mac_node_serial.sv
// mac_node_serial: serial MAC neuron (weights x activations + bias, rescale, saturate, ReLU); MAC_NODE_LEAKY_RELU_EN selects leaky ReLU
module mac_node_serial #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8,
    parameter int N_INPUTS  = 10,
    parameter int AW        = $clog2(N_INPUTS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    w_we,
    input  logic [AW-1:0]           w_addr,
    input  logic signed [WIDTH-1:0] w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data
);
    localparam int ACC_W = 2*WIDTH + $clog2(N_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    typedef enum logic {ACC, OUT} state_t;
    state_t state;
    logic [AW-1:0] cnt;
    logic signed [ACC_W-1:0] acc, base, sum, r;
    logic signed [WIDTH-1:0] w [0:N_INPUTS];
    logic signed [WIDTH-1:0] sat, act;
    logic last;
    // the first beat of a vector starts from the bias as it stands now, so a bias written before beat 0 applies to this vector
    assign base = (cnt == '0) ? (ACC_W'(w[N_INPUTS]) <<< FRAC_BITS) : acc;
    assign sum = base + ACC_W'(in_data) * ACC_W'(w[cnt]);
    assign r = sum >>> FRAC_BITS;
    assign sat = (r > MAXV) ? {1'b0, {(WIDTH-1){1'b1}}} : (r < MINV) ? {1'b1, {(WIDTH-1){1'b0}}} : r[WIDTH-1:0];
`ifdef MAC_NODE_LEAKY_RELU_EN
    assign act = sat[WIDTH-1] ? (sat >>> 3) : sat;
`else
    assign act = sat[WIDTH-1] ? '0 : sat;
`endif
    assign last = (cnt == AW'(N_INPUTS - 1));
    assign in_ready = (state == ACC);
    assign out_valid = (state == OUT);
    // accumulate beats, latch the activated result on the last beat, hold it until accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ACC;
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
        end else if (state == ACC) begin
            if (in_valid) begin
                acc <= sum;
                cnt <= last ? '0 : cnt + AW'(1);
                if (last) begin
                    state    <= OUT;
                    out_data <= act;
                end
            end
        end else if (out_ready) begin
            state <= ACC;
        end
    end
    // weight/bias file; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= N_INPUTS; i++) w[i] <= '0;
        end else if (w_we && w_addr <= AW'(N_INPUTS)) begin
            w[w_addr] <= w_data;
        end
    end
endmodule

// File: tb/tb_mac_node_serial.sv
// tb_mac_node_serial: scoreboard bench for mac_node_serial with a vector-level reference model
module tb_mac_node_serial;
    localparam int N = 4;
    localparam int F = 8;
    logic clk, reset, in_valid, in_ready, w_we, out_valid, out_ready;
    logic [15:0] in_data, w_data, out_data;
    logic [2:0] w_addr;
    int checks = 0, errors = 0;
    logic signed [15:0] wm [0:N];
    longint msum;
    int mk = 0;
    logic [15:0] q [$];
    bit rnd = 0;
    logic pv = 0;
    logic [15:0] pd;

    mac_node_serial #(.WIDTH(16), .FRAC_BITS(F), .N_INPUTS(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] act(input longint s);
        longint r = s >>> F;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef MAC_NODE_LEAKY_RELU_EN
        if (r < 0) r = r >>> 3;
`else
        if (r < 0) r = 0;
`endif
        return 16'(r);
    endfunction

    function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
        if (a <= 3'(N)) wm[a] = d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i <= N; i++) wm[i] = 0;
        mk = 0;
        q.delete();
    endfunction

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        w_we = 1; w_addr = a; w_data = d;
        model_write(a, d);
        @(posedge clk); #1;
        w_we = 0;
    endtask

    task automatic beat(input logic [15:0] x, input bit we = 0, input logic [2:0] a = '0, input logic [15:0] d = '0);
        bit ok, done;
        int n = 0;
        done = 0;
        in_valid = 1; in_data = x; w_we = we; w_addr = a; w_data = d;
        do begin
            ok = in_ready;
            if (ok) begin
                if (mk == 0) msum = longint'(wm[N]) <<< F;
                msum += longint'($signed(x)) * longint'(wm[mk]);
                mk++;
                if (mk == N) begin
                    q.push_back(act(msum));
                    mk = 0;
                    done = 1;
                end
            end
            if (w_we) model_write(w_addr, w_data);
            @(posedge clk); #1;
            w_we = 0;
            n++;
        end while (!ok && n < 50);
        in_valid = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready low for %0d cycles, required high", n);
        end
        if (done) chk("latency_out_valid", {15'b0, out_valid}, 16'd1);
    endtask

    task automatic vec(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3);
        beat(a0); beat(a1); beat(a2); beat(a3);
    endtask

    function automatic logic [15:0] rv(input bit big);
        return big ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
    endfunction

    initial forever begin
        @(posedge clk); #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!reset) begin
            pv = 0;
        end else begin
            if (pv) begin
                chk("hold_data", out_data, pd);
                chk("hold_ready_valid", {14'b0, in_ready, out_valid}, 16'd1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got %h with none required", out_data);
                end else begin
                    chk("result", out_data, q.pop_front());
                end
                pv = 0;
            end else begin
                pv = out_valid;
                pd = out_data;
            end
        end
    end

    initial begin
        reset = 0; in_valid = 0; in_data = 0; w_we = 0; w_addr = 0; w_data = 0; out_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {15'b0, out_valid}, 16'd0);
        chk("reset_out_data", out_data, 16'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        chk("reset_in_ready", {15'b0, in_ready}, 16'd1);
        // basic MAC
        for (int i = 0; i < N; i++) wr(3'(i), 16'd256);
        vec(16'd256, 16'd512, -16'sd256, 16'd0);
        // bias and ReLU
        wr(3'(N), -16'sd768);
        vec(16'd256, 16'd256, 16'd0, 16'd0);
        wr(3'(N), 16'd128);
        vec(16'd256, 16'd256, 16'd0, 16'd0);
        // saturation
        wr(3'(N), 16'd0);
        for (int i = 0; i < N; i++) wr(3'(i), 16'h7FFF);
        vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < N; i++) wr(3'(i), 16'h8000);
        vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        // backpressure
        for (int i = 0; i < N; i++) wr(3'(i), 16'd256);
        out_ready = 0;
        vec(16'd256, 16'd512, 16'd768, 16'd1024);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 16'h1234;
            @(posedge clk); #1;
            chk("bp_in_ready", {15'b0, in_ready}, 16'd0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {15'b0, in_ready}, 16'd1);
        chk("bp_release_out_valid", {15'b0, out_valid}, 16'd0);
        // weight write collision and illegal address
        beat(16'd256, 1, 3'd0, 16'd512);
        beat(16'd0, 1, 3'd7, 16'h1111);
        beat(16'd0); beat(16'd0);
        vec(16'd256, 16'd0, 16'd0, 16'd0);
        // async reset mid-vector
        beat(16'd256); beat(16'd256);
        #2 reset = 0;
        #1;
        chk("midreset_out_valid", {15'b0, out_valid}, 16'd0);
        chk("midreset_out_data", out_data, 16'd0);
        model_reset();
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        vec(rv(1), rv(1), rv(1), rv(1));
        // randomized traffic with concurrent writes and backpressure
        for (int i = 0; i <= N; i++) wr(3'(i), rv(0));
        rnd = 1;
        for (int v = 0; v < 40; v++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                beat(rv(v >= 20), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), rv(v >= 30));
            end
        end
        rnd = 0;
        out_ready = 1;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
